// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands in a small FIFO and issues them one at a time to an
// external combinational ALU. Each result is captured and held as a response until downstream
// takes it.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   cmd_valid/cmd_ready                command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op               command operands and opcode
//   alu_a, alu_b, alu_opcode           operands/opcode to the ALU (hold last issued values)
//   alu_result                         combinational ALU result
//   rsp_valid/rsp_ready                response handshake
//   rsp_result, rsp_op, rsp_err        captured result, its opcode, invalid-opcode flag
//   rsp_count                          responses handed off since reset, modulo 256
//   busy                               FIFO non-empty or a command in flight
module alu_cmd_issuer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [3:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic [7:0] rsp_count,
  output logic       busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state_q;
  logic [10:0]     mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [10:0]     head;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(DEPTH));
  // Depends only on occupancy, so there is no path from cmd_valid to cmd_ready.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign head       = mem[rd_ptr_q];
  assign busy       = !fifo_empty || (state_q != StIdle);

  // FIFO storage needs no reset: entries are only read when occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Issue FSM. alu_a/alu_b/alu_opcode double as the issue registers, so they keep the last
  // issued command outside ISSUE instead of returning to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
      rsp_count  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            {alu_a, alu_b, alu_opcode} <= head;
            state_q                    <= StIssue;
          end
        end
        StIssue: begin
          // Invalid opcodes still go through the ALU; its result is captured as-is.
          rsp_result <= alu_result;
          rsp_op     <= alu_opcode;
          rsp_err    <= (alu_opcode > 3'b100);
          rsp_valid  <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_count <= rsp_count + 8'd1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_alu_cmd_issuer;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [2:0] rsp_op;
  logic       rsp_err;
  logic [7:0] rsp_count;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_op    (rsp_op),
    .rsp_err   (rsp_err),
    .rsp_count (rsp_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted commands sit in a queue; at most one is in flight, moving through
  // issue (one cycle) and then a held response until downstream takes it.
  cmd_t       q[$];
  cmd_t       cur;
  cmd_t       nc;
  logic       take;
  int         phase;  // 0 waiting for work, 1 issuing, 2 holding response
  logic       model_on = 1'b0;
  logic [3:0] m_alu_a, m_alu_b, m_res;
  logic [2:0] m_alu_op, m_op;
  logic       m_err, m_valid;
  logic [7:0] m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      phase    = 0;
      m_alu_a  = '0;
      m_alu_b  = '0;
      m_alu_op = '0;
      m_res    = '0;
      m_op     = '0;
      m_err    = 1'b0;
      m_valid  = 1'b0;
      m_cnt    = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      take = cmd_valid && (q.size() < DEPTH);
      nc   = {cmd_a, cmd_b, cmd_op};
      case (phase)
        0: if (q.size() != 0) begin
          cur      = q.pop_front();
          m_alu_a  = cur.a;
          m_alu_b  = cur.b;
          m_alu_op = cur.op;
          phase    = 1;
        end
        1: begin
          m_res   = alu_fn(cur.a, cur.b, cur.op);
          m_op    = cur.op;
          m_err   = (cur.op >= 3'd5);
          m_valid = 1'b1;
          phase   = 2;
        end
        default: if (rsp_ready) begin
          m_valid = 1'b0;
          m_cnt   = m_cnt + 8'd1;
          phase   = 0;
        end
      endcase
      if (take) q.push_back(nc);
    end
  end

  // Compare process: outputs only change on posedge, so sample on negedge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("cmd_ready",  32'(cmd_ready),  32'(q.size() < DEPTH));
      chk("busy",       32'(busy),       32'((q.size() != 0) || (phase != 0)));
      chk("alu_a",      32'(alu_a),      32'(m_alu_a));
      chk("alu_b",      32'(alu_b),      32'(m_alu_b));
      chk("alu_opcode", 32'(alu_opcode), 32'(m_alu_op));
      chk("rsp_valid",  32'(rsp_valid),  32'(m_valid));
      chk("rsp_result", 32'(rsp_result), 32'(m_res));
      chk("rsp_op",     32'(rsp_op),     32'(m_op));
      chk("rsp_err",    32'(rsp_err),    32'(m_err));
      chk("rsp_count",  32'(rsp_count),  32'(m_cnt));
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_timeout"}, 32'(got), 32'd1);
  endtask

  int acc;
  int hs;
  int stale;
  logic seen255;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready),  32'd1);
    chk("reset_busy",      32'(busy),       32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid),  32'd0);
    chk("reset_rsp_count", 32'(rsp_count),  32'd0);
    chk("reset_alu_a",     32'(alu_a),      32'd0);

    // 3 + 5 add: two-edge latency, then one handshake.
    send(4'd3, 4'd5, 3'd0);
    chk("lat_n0_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_n1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(rsp_valid), 32'd1);
    chk("add_result",   32'(rsp_result), 32'd8);
    chk("add_err",      32'(rsp_err),    32'd0);
    @(negedge clk);
    chk("add_count",    32'(rsp_count),  32'd1);
    chk("add_valid_dn", 32'(rsp_valid),  32'd0);

    send(4'd2, 4'd3, 3'd1);
    wait_rsp("sub");
    chk("sub_result", 32'(rsp_result), 32'd15);
    @(negedge clk);
    send(4'd5, 4'd0, 3'd4);
    wait_rsp("nota");
    chk("nota_result", 32'(rsp_result), 32'd10);
    @(negedge clk);
    send(4'd7, 4'd1, 3'd6);
    wait_rsp("inv");
    chk("inv_result", 32'(rsp_result), 32'd0);
    chk("inv_err",    32'(rsp_err),    32'd1);
    chk("inv_op",     32'(rsp_op),     32'd6);
    repeat (2) @(negedge clk);

    // Backpressure: 6 back-to-back pushes, 5 fit (4 queued + 1 in flight).
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_a     = 4'(i + 1);
      cmd_b     = 4'(i);
      cmd_op    = 3'd0;
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp("bp_rsp");
      chk("bp_order", 32'(rsp_result), 32'(2 * k + 1));
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Reset while holding a response with 3 more queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_a     = 4'(i + 9);
      cmd_b     = 4'd1;
      cmd_op    = 3'd3;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
    chk("mid_pre_busy",  32'(busy),      32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy",      32'(busy),      32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rsp_count", 32'(rsp_count), 32'd0);
    rsp_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);

    // 256 handshakes wrap rsp_count back to zero.
    acc = 0;
    hs = 0;
    seen255 = 1'b0;
    for (int c = 0; c < 2000 && hs < 256; c++) begin
      cmd_valid = (acc < 256);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_op    = 3'($urandom_range(0, 7));
      if (cmd_valid && cmd_ready) acc++;
      if (rsp_valid && rsp_ready) hs++;
      @(negedge clk);
      if (hs == 255 && !seen255) begin
        seen255 = 1'b1;
        chk("cnt_255", 32'(rsp_count), 32'd255);
      end
    end
    cmd_valid = 1'b0;
    chk("cnt_hs", 32'(hs), 32'd256);
    chk("cnt_wrap", 32'(rsp_count), 32'd0);

    // Randomized traffic with varying backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_op    = 3'($urandom_range(0, 7));
      if (((c / 400) % 2) == 0) rsp_ready = ($urandom_range(0, 3) != 0);
      else                      rsp_ready = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
